sim_run_dump_ctrl: RTL and testbench
====================================

// Module: sim_run_dump_ctrl
// PURPOSE
//  Run-control and register-dump sequencer for the pipelined CPU simulator top. Enables the core
//  for a bounded cycle budget, stops early on a halt request, drains the pipeline, then
//  walks the register file and streams each entry out over a valid/ready port.
//  Replaces the fixed end-of-run cycle count and print loop with synthesizable, parametrised control.
// PARAMETERS
//  DATA_W       32   register-file data width
//  REG_CNT      32   number of registers dumped (indices 0..REG_CNT-1)
//  ADDR_W       5    register index width, >= clog2(REG_CNT)
//  CYC_W        16   cycle counter / budget width
//  MAX_CYCLES   100  default budget, used when max_cycles_i == 0
//  DRAIN_CYC    4    cycles the core keeps running with fetch stalled after stop
//  RF_RD_LAT    1    register-file read latency in cycles (0 or 1)
// PORTS
//  clk_i           in   1        clock, rising edge
//  rst_i           in   1        synchronous, active-high reset
//  start_i         in   1        1-cycle pulse; begins a run from IDLE or DONE
//  max_cycles_i    in   CYC_W    cycle budget, sampled on the accepted start; 0 selects MAX_CYCLES
//  halt_req_i      in   1        core reports a halt instruction; honoured in RUN only
//  cpu_en_o        out  1        core clock enable
//  fetch_stall_o   out  1        freeze PC/fetch (asserted in DRAIN)
//  rf_raddr_o      out  ADDR_W   register-file debug read address
//  rf_rdata_i      in   DATA_W   register-file debug read data
//  dump_valid_o    out  1        dump entry valid
//  dump_ready_i    in   1        consumer accepts the entry
//  dump_idx_o      out  ADDR_W   index of the current entry
//  dump_data_o     out  DATA_W   value of the current entry
//  dump_last_o     out  1        current entry is index REG_CNT-1
//  cycle_cnt_o     out  CYC_W    RUN cycles executed in this run
//  halt_reason_o   out  2        00 none, 01 budget, 10 halt_req, 11 both in the same cycle
//  busy_o          out  1        state != IDLE and != DONE
//  done_o          out  1        high in DONE
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; counters and index 0. A reset in any state aborts
//    the run the next cycle with no partial dump.
//  - FSM: IDLE -start-> RUN -stop-> DRAIN -DRAIN_CYC done-> RD -> OUT -accept-> RD | DONE;
//    DONE -start-> RUN. start_i is ignored in RUN, DRAIN, RD and OUT.
//  - On an accepted start: budget latched (0 -> MAX_CYCLES); cycle_cnt_o, halt_reason_o
//    and the dump index cleared.
//  - RUN: cpu_en_o=1 and cycle_cnt_o increments by 1 each cycle. Stop condition, evaluated
//    in the same cycle: cycle_cnt_o+1 == budget (count of executed cycles reaches budget)
//    or halt_req_i. The next state is DRAIN and halt_reason_o is latched. With budget B
//    and no halt, cpu_en_o is high for exactly B cycles in RUN, and cycle_cnt_o ends at B.
//  - DRAIN: cpu_en_o=1 and fetch_stall_o=1 for exactly DRAIN_CYC cycles;
//    cycle_cnt_o is frozen. DRAIN_CYC=0 skips straight to RD.
//  - RD: cpu_en_o=0 and rf_raddr_o=index. Lasts RF_RD_LAT cycles (zero-time when the
//    latency is 0). rf_rdata_i is then captured into dump_data_o.
//  - OUT: dump_valid_o=1; dump_idx_o, dump_data_o and dump_last_o stay stable until
//    dump_ready_i. On accept: if last, go to DONE; otherwise the index increments and the
//    state returns to RD. Throughput is 1 entry per cycle at RF_RD_LAT=0 and 1 entry per
//    2 cycles at RF_RD_LAT=1.
//  - DONE: done_o=1. cycle_cnt_o and halt_reason_o hold until the next start. dump_valid_o=0.
//  - Counters never wrap. The budget fits in CYC_W by construction. The index stops at REG_CNT-1.
//  - Reaching the budget and asserting halt_req_i in the same cycle gives halt_reason_o=11.
// STRUCTURE
//  - Shared package sim_ctrl_pkg: state enum {IDLE,RUN,DRAIN,RD,OUT,DONE} and the
//    halt-reason encodings. Used by the top and by the bench scoreboard.
//  - One sub-module, sim_dump_seq: the RD/OUT index walker and the valid/ready output
//    register. The top holds the FSM, the budget logic and the cycle counter.
// TESTING
//  1. max_cycles_i=0, no halt, dump_ready_i=1 -> cpu_en_o high 100 RUN cycles + 4 DRAIN;
//     cycle_cnt_o=100; halt_reason_o=01; 32 entries idx 0..31, dump_last_o only on idx 31.
//  2. max_cycles_i=50, halt_req_i pulsed in RUN cycle 10 -> cycle_cnt_o=10,
//     halt_reason_o=10, fetch_stall_o high exactly 4 cycles.
//  3. max_cycles_i=8, halt_req_i asserted in the 8th RUN cycle -> halt_reason_o=11, cycle_cnt_o=8.
//  4. dump_ready_i low for 3 cycles on idx 5 -> idx 5 and its data held stable and valid for
//     those 3 cycles; no index skipped or repeated; values match the register-file model.
//  5. rst_i asserted during OUT at idx 12 -> next cycle all outputs 0, IDLE;
//     a later start gives a full run and a dump from idx 0.
//  6. start_i pulsed during RUN -> ignored. start_i in DONE -> new run, cycle_cnt_o restarts at 0.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulator run-control / register-dump sequencer.
package sim_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_RD    = 3'd3,
      ST_OUT   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [1:0] HALT_NONE   = 2'b00;
   localparam logic [1:0] HALT_BUDGET = 2'b01;
   localparam logic [1:0] HALT_REQ    = 2'b10;
   localparam logic [1:0] HALT_BOTH   = 2'b11;

   function automatic logic [1:0] halt_code(input logic budget_hit, input logic halt_req);
      return {halt_req, budget_hit};
   endfunction

endpackage

// File: rtl/sim_dump_seq.sv
// Register-dump index walker and valid/ready output register.
module sim_dump_seq
   import sim_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_CNT = 32,
   parameter int ADDR_W  = 5
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              cap_i,
   input  logic              out_i,
   input  logic              ready_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [ADDR_W-1:0] raddr_o,
   output logic [ADDR_W-1:0] idx_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic              valid_o,
   output logic              accept_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_CNT - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] data;
   logic              at_last;
   logic              advance;

   assign at_last  = (idx == LAST_IDX);
   assign accept_o = out_i && ready_i;
   assign advance  = accept_o && !at_last;

   // Present the upcoming index during the accept cycle so a registered
   // register file has the next entry ready by the end of RD.
   assign raddr_o  = advance ? idx + IDX_ONE : idx;
   assign idx_o    = idx;
   assign data_o   = data;
   assign last_o   = out_i && at_last;
   assign valid_o  = out_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx  <= '0;
         data <= '0;
      end else begin
         if (clr_i)
            idx <= '0;
         else if (advance)
            idx <= idx + IDX_ONE;
         if (clr_i)
            data <= '0;
         else if (cap_i)
            data <= rdata_i;
      end
   end

endmodule

// File: rtl/sim_run_dump_ctrl.sv
// Run-control FSM: bounded RUN, pipeline DRAIN, then register-file dump.
module sim_run_dump_ctrl
   import sim_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_CNT    = 32,
   parameter int ADDR_W     = 5,
   parameter int CYC_W      = 16,
   parameter int MAX_CYCLES = 100,
   parameter int DRAIN_CYC  = 4,
   parameter int RF_RD_LAT  = 1
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [CYC_W-1:0]  max_cycles_i,
   input  logic              halt_req_i,
   output logic              cpu_en_o,
   output logic              fetch_stall_o,
   output logic [ADDR_W-1:0] rf_raddr_o,
   input  logic [DATA_W-1:0] rf_rdata_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_idx_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic              dump_last_o,
   output logic [CYC_W-1:0]  cycle_cnt_o,
   output logic [1:0]        halt_reason_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int               DRN_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);
   localparam logic [DRN_W-1:0] DRN_ONE    = DRN_W'(1);
   localparam logic [CYC_W-1:0] DEF_BUDGET = CYC_W'(MAX_CYCLES);
   localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
   localparam state_t           RD_ENTRY   = (RF_RD_LAT == 0) ? ST_OUT : ST_RD;
   localparam state_t           RUN_EXIT   = (DRAIN_CYC == 0) ? RD_ENTRY : ST_DRAIN;

   state_t            state, nxt;
   logic [CYC_W-1:0]  budget;
   logic [CYC_W-1:0]  cyc;
   logic [1:0]        reason;
   logic [DRN_W-1:0]  drn;
   logic              start_ok, budget_hit, stop, drain_end, accept, cap;

   assign start_ok   = start_i && (state == ST_IDLE || state == ST_DONE);
   assign budget_hit = (cyc + CYC_ONE) == budget;
   assign stop       = (state == ST_RUN) && (budget_hit || halt_req_i);
   assign drain_end  = (state == ST_DRAIN) && (drn == DRAIN_LAST);
   // Capture whenever OUT is entered fresh; a stalled OUT keeps its entry.
   assign cap        = (nxt == ST_OUT) && (state != ST_OUT || accept);

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start_i)   nxt = ST_RUN;
         ST_RUN:           if (stop)      nxt = RUN_EXIT;
         ST_DRAIN:         if (drain_end) nxt = RD_ENTRY;
         ST_RD:                           nxt = ST_OUT;
         ST_OUT:           if (accept)    nxt = dump_last_o ? ST_DONE : RD_ENTRY;
         default:                         nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= ST_IDLE;
         budget <= '0;
         cyc    <= '0;
         reason <= HALT_NONE;
         drn    <= '0;
      end else begin
         state <= nxt;
         if (start_ok) begin
            budget <= (max_cycles_i == '0) ? DEF_BUDGET : max_cycles_i;
            cyc    <= '0;
            reason <= HALT_NONE;
         end else if (state == ST_RUN) begin
            cyc <= cyc + CYC_ONE;
            if (stop)
               reason <= halt_code(budget_hit, halt_req_i);
         end
         drn <= (state == ST_DRAIN) ? drn + DRN_ONE : '0;
      end
   end

   sim_dump_seq #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT),
      .ADDR_W  (ADDR_W)
   ) u_dump (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (start_ok),
      .cap_i    (cap),
      .out_i    (state == ST_OUT),
      .ready_i  (dump_ready_i),
      .rdata_i  (rf_rdata_i),
      .raddr_o  (rf_raddr_o),
      .idx_o    (dump_idx_o),
      .data_o   (dump_data_o),
      .last_o   (dump_last_o),
      .valid_o  (dump_valid_o),
      .accept_o (accept)
   );

   assign cpu_en_o      = (state == ST_RUN) || (state == ST_DRAIN);
   assign fetch_stall_o = (state == ST_DRAIN);
   assign cycle_cnt_o   = cyc;
   assign halt_reason_o = reason;
   assign busy_o        = (state != ST_IDLE) && (state != ST_DONE);
   assign done_o        = (state == ST_DONE);

endmodule

// File: tb/tb_sim_run_dump_ctrl.sv
// Directed bench for sim_run_dump_ctrl with a registered-read register-file model.
module tb_sim_run_dump_ctrl;
   import sim_ctrl_pkg::*;

   localparam int REG_CNT = 32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] max_cycles;
   logic        halt_req;
   logic        cpu_en;
   logic        fetch_stall;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        valid;
   logic        ready;
   logic [4:0]  idx;
   logic [31:0] data;
   logic        last;
   logic [15:0] cycle_cnt;
   logic [1:0]  reason;
   logic        busy;
   logic        done;

   int n_chk  = 0;
   int n_pass = 0;

   sim_run_dump_ctrl #(
      .DATA_W     (32),
      .REG_CNT    (REG_CNT),
      .ADDR_W     (5),
      .CYC_W      (16),
      .MAX_CYCLES (100),
      .DRAIN_CYC  (4),
      .RF_RD_LAT  (1)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .max_cycles_i  (max_cycles),
      .halt_req_i    (halt_req),
      .cpu_en_o      (cpu_en),
      .fetch_stall_o (fetch_stall),
      .rf_raddr_o    (raddr),
      .rf_rdata_i    (rdata),
      .dump_valid_o  (valid),
      .dump_ready_i  (ready),
      .dump_idx_o    (idx),
      .dump_data_o   (data),
      .dump_last_o   (last),
      .cycle_cnt_o   (cycle_cnt),
      .halt_reason_o (reason),
      .busy_o        (busy),
      .done_o        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rf_val(input int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0013);
   endfunction

   // One-cycle registered read port
   always @(posedge clk) rdata <= rf_val(int'(raddr));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " cpu_en"},  64'(cpu_en), 0);
      check({tag, " stall"},   64'(fetch_stall), 0);
      check({tag, " valid"},   64'(valid), 0);
      check({tag, " idx"},     64'(idx), 0);
      check({tag, " data"},    64'(data), 0);
      check({tag, " last"},    64'(last), 0);
      check({tag, " raddr"},   64'(raddr), 0);
      check({tag, " cyc"},     64'(cycle_cnt), 0);
      check({tag, " reason"},  64'(reason), 64'(HALT_NONE));
      check({tag, " busy"},    64'(busy), 0);
      check({tag, " done"},    64'(done), 0);
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic do_run(input string tag, input int max_c, input int halt_at, input int start_at,
                         input int stall_idx, input int exp_run, input logic [1:0] exp_reason);
      int run_n = 0, drn_n = 0, ent = 0, stall_left = 3, t = 0;
      int hold_bad = 0, en_bad = 0, last_bad = 0;
      bit prev_stall = 0;
      max_cycles = 16'(max_c);
      start = 1'b1;
      @(negedge clk);
      while (!done && t < 3000) begin
         start = 1'b0; halt_req = 1'b0; ready = 1'b1;
         if (prev_stall && !(valid && int'(idx) == stall_idx && data == rf_val(stall_idx)))
            hold_bad++;
         prev_stall = 0;
         if (cpu_en && !fetch_stall) begin
            run_n++;
            if (run_n == 1) begin
               check({tag, " cnt0"}, 64'(cycle_cnt), 0);
               check({tag, " reason0"}, 64'(reason), 64'(HALT_NONE));
            end
            if (run_n == halt_at)  halt_req = 1'b1;
            if (run_n == start_at) start = 1'b1;
         end else if (fetch_stall) begin
            drn_n++;
            if (!cpu_en) en_bad++;
         end
         if (valid) begin
            if (cpu_en) en_bad++;
            if (int'(idx) == stall_idx && stall_left > 0) begin
               ready = 1'b0; stall_left--; prev_stall = 1;
            end else begin
               check($sformatf("%s idx%0d", tag, ent), 64'(idx), 64'(ent));
               check($sformatf("%s data%0d", tag, ent), 64'(data), 64'(rf_val(ent)));
               check($sformatf("%s last%0d", tag, ent), 64'(last), 64'(ent == REG_CNT - 1));
               ent++;
            end
         end else if (last) begin
            last_bad++;
         end
         @(negedge clk);
         t++;
      end
      start = 1'b0; halt_req = 1'b0;
      check({tag, " done"},      64'(done), 1);
      check({tag, " run_cyc"},   64'(run_n), 64'(exp_run));
      check({tag, " drain_cyc"}, 64'(drn_n), 4);
      check({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(exp_run));
      check({tag, " reason"},    64'(reason), 64'(exp_reason));
      check({tag, " entries"},   64'(ent), 64'(REG_CNT));
      check({tag, " valid_end"}, 64'(valid), 0);
      check({tag, " busy_end"},  64'(busy), 0);
      check({tag, " hold"},      64'(hold_bad), 0);
      check({tag, " en"},        64'(en_bad), 0);
      check({tag, " stray_last"}, 64'(last_bad), 0);
   endtask

   initial begin
      int t;
      rst = 1'b1; start = 1'b0; halt_req = 1'b0; ready = 1'b0; max_cycles = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      do_run("t1", 0, 0, 0, -1, 100, HALT_BUDGET);
      do_run("t2", 50, 10, 0, -1, 10, HALT_REQ);
      do_run("t3", 8, 8, 0, -1, 8, HALT_BOTH);
      do_run("t4", 3, 0, 2, 5, 3, HALT_BUDGET);

      max_cycles = 16'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; ready = 1'b1;
      t = 0;
      while (!(valid && idx == 5'd12) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("t5 reach idx12", 64'(valid && idx == 5'd12), 1);
      rst = 1'b1; ready = 1'b0;
      @(negedge clk);
      check_idle("t5 abort");
      rst = 1'b0;
      @(negedge clk);
      check("t5 idle busy", 64'(busy), 0);
      check("t5 idle done", 64'(done), 0);
      do_run("t5b", 0, 0, 0, -1, 100, HALT_BUDGET);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
